// File: rtl/alu_exec_stage_if.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_if
// Bundles the operand-side and result-side valid/ready handshakes of the
// ALU execute stage into one interface. Clock and reset stay plain ports on
// the module.
//
//   in_valid  / in_ready   : operand bundle handshake (producer -> stage)
//   alu_op                 : 4-bit operation code
//   rs1_data / rs2_data    : operand A / operand B (register form)
//   imm / use_imm          : sign-extended immediate and its select
//   rd_in                  : destination register index carried with the op
//   out_valid / out_ready  : result handshake (stage -> register bank)
//   alu_out / rd_out       : result and its destination index
//   busy                   : iterative shift in progress
//
// Modports:
//   master : the producer/consumer side (drives operands and out_ready)
//   slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface alu_exec_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [REG_AW-1:0] rd_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   alu_out;
    logic [REG_AW-1:0] rd_out;
    logic              busy;

    modport master (
        output in_valid, alu_op, rs1_data, rs2_data, imm, use_imm, rd_in, out_ready,
        input  in_ready, out_valid, alu_out, rd_out, busy
    );

    modport slave (
        input  in_valid, alu_op, rs1_data, rs2_data, imm, use_imm, rd_in, out_ready,
        output in_ready, out_valid, alu_out, rd_out, busy
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// RV32I integer execute stage sitting right after the register bank. Takes
// rs1/rs2 (or an immediate), computes the ALU result and holds exactly one
// result in an output register until the register-bank write port takes it.
//
// Ports:
//   stage_clk : stage clock, all state changes on the rising edge
//   reset     : synchronous, active-high reset
//   bus       : alu_exec_stage_if.slave (operand handshake, result
//               handshake, busy flag)
//
// Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//           8 OR, 9 AND, 10 PASSB; 11-15 produce 0 with ADD timing.
//
// Build option:
//   SHIFT_FAST_EN : when defined, shifts use a single-cycle barrel shifter,
//                   every op has latency 1 and busy is always 0. When not
//                   defined, shifts by k>0 move one bit per cycle and the
//                   result appears k+1 cycles after accept.
// ---------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              stage_clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q,    state_d;
    logic              outValid_q, outValid_d;
    logic [XLEN-1:0]   aluOut_q,   aluOut_d;
    logic [REG_AW-1:0] rdOut_q,    rdOut_d;
    logic [XLEN-1:0]   shiftVal_q, shiftVal_d;
    logic [3:0]        shiftOp_q,  shiftOp_d;
    logic [4:0]        count_q,    count_d;
    logic [REG_AW-1:0] rdHold_q,   rdHold_d;

    logic [XLEN-1:0]   opA;
    logic [XLEN-1:0]   opB;
    logic [4:0]        shamt;
    logic              inReady;
    logic              accept;
    logic              goIterative;
    logic [XLEN-1:0]   immResult;
    logic [XLEN-1:0]   oneStep;

    // Operand selection and the handshake terms. A new bundle can only be
    // taken in IDLE and only when the output register is empty or is being
    // drained at this very edge.
    assign opA     = bus.rs1_data;
    assign opB     = bus.use_imm ? bus.imm : bus.rs2_data;
    assign shamt   = opB[4:0];
    assign inReady = (state_q == IDLE) && (!outValid_q || bus.out_ready);
    assign accept  = bus.in_valid && inReady;

    // Decide whether an accepted op has to go through the bit-serial
    // shifter. A shift by zero is just a pass of operand A, so it takes the
    // single-cycle path.
`ifdef SHIFT_FAST_EN
    assign goIterative = 1'b0;
`else
    logic isShiftOp;
    assign isShiftOp   = (bus.alu_op == OP_SLL) || (bus.alu_op == OP_SRL) ||
                         (bus.alu_op == OP_SRA);
    assign goIterative = isShiftOp && (shamt != 5'd0);
`endif

    // Single-cycle result for everything that finishes at the accept edge.
    // In the iterative build shifts only arrive here with shamt==0, where
    // the result is operand A unchanged.
    always_comb begin
        immResult = '0;
        case (bus.alu_op)
            OP_ADD:   immResult = opA + opB;
            OP_SUB:   immResult = opA - opB;
            OP_SLT:   immResult = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_SLTU:  immResult = {{(XLEN-1){1'b0}}, (opA < opB)};
            OP_XOR:   immResult = opA ^ opB;
            OP_OR:    immResult = opA | opB;
            OP_AND:   immResult = opA & opB;
            OP_PASSB: immResult = opB;
`ifdef SHIFT_FAST_EN
            OP_SLL:   immResult = opA << shamt;
            OP_SRL:   immResult = opA >> shamt;
            OP_SRA:   immResult = $signed(opA) >>> shamt;
`else
            OP_SLL, OP_SRL, OP_SRA: immResult = opA;
`endif
            default:  immResult = '0;
        endcase
    end

    // One bit of shifting for the iterative path. SRA copies the sign bit
    // into the vacated MSB on every step.
    always_comb begin
        oneStep = '0;
        case (shiftOp_q)
            OP_SLL:  oneStep = {shiftVal_q[XLEN-2:0], 1'b0};
            OP_SRA:  oneStep = {shiftVal_q[XLEN-1], shiftVal_q[XLEN-1:1]};
            default: oneStep = {1'b0, shiftVal_q[XLEN-1:1]};
        endcase
    end

    // Next-state logic. In IDLE the output register drains when the
    // consumer takes it, and an accept at the same edge may refill it
    // immediately, which is what allows one ADD per cycle. In SHIFT the
    // counter runs down to zero and the edge after that loads the result,
    // giving k+1 cycles from accept to valid.
    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q;
        aluOut_d   = aluOut_q;
        rdOut_d    = rdOut_q;
        shiftVal_d = shiftVal_q;
        shiftOp_d  = shiftOp_q;
        count_d    = count_q;
        rdHold_d   = rdHold_q;

        case (state_q)
            IDLE: begin
                if (outValid_q && bus.out_ready) begin
                    outValid_d = 1'b0;
                end
                if (accept) begin
                    rdHold_d = bus.rd_in;
                    if (goIterative) begin
                        state_d    = SHIFT;
                        shiftVal_d = opA;
                        shiftOp_d  = bus.alu_op;
                        count_d    = shamt;
                    end else begin
                        aluOut_d   = immResult;
                        rdOut_d    = bus.rd_in;
                        outValid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (count_q != 5'd0) begin
                    shiftVal_d = oneStep;
                    count_d    = count_q - 5'd1;
                end else begin
                    aluOut_d   = shiftVal_q;
                    rdOut_d    = rdHold_q;
                    outValid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset is synchronous and takes priority over any
    // handshake happening at the same edge, discarding an in-flight shift.
    always_ff @(posedge stage_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            aluOut_q   <= '0;
            rdOut_q    <= '0;
            shiftVal_q <= '0;
            shiftOp_q  <= '0;
            count_q    <= '0;
            rdHold_q   <= '0;
        end else begin
            state_q    <= state_d;
            outValid_q <= outValid_d;
            aluOut_q   <= aluOut_d;
            rdOut_q    <= rdOut_d;
            shiftVal_q <= shiftVal_d;
            shiftOp_q  <= shiftOp_d;
            count_q    <= count_d;
            rdHold_q   <= rdHold_d;
        end
    end

    // Drive the interface outputs straight from the registers.
    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.alu_out   = aluOut_q;
    assign bus.rd_out    = rdOut_q;
`ifdef SHIFT_FAST_EN
    assign bus.busy      = 1'b0;
`else
    assign bus.busy      = (state_q == SHIFT);
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Directed bench for alu_exec_stage: reset in the middle of a long shift,
// basic arithmetic, iterative shift latency, compares and illegal op,
// output backpressure with same-edge retire/accept, and an 8-deep stream.
// Expected latency for shifts follows SHIFT_FAST_EN.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

    logic clk = 1'b0;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;

    alu_exec_stage_if #(.XLEN(32), .REG_AW(5)) bus();

    alu_exec_stage #(.XLEN(32), .REG_AW(5)) dut (
        .stage_clk (clk),
        .reset     (reset),
        .bus       (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One immediate assertion per comparison; failures are counted and
    // reported with observed and expected values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Present an operand bundle with in_valid high (no clock advance).
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic ui, input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.imm      = im;
        bus.use_imm  = ui;
        bus.rd_in    = rd;
    endtask

    // Present a bundle for exactly one edge, then drop in_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic ui, input logic [4:0] rd);
        applyStimulus(op, a, b, im, ui, rd);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int expLat;
        logic expBusy;

`ifdef SHIFT_FAST_EN
        expLat  = 0;
        expBusy = 1'b0;
`else
        expLat  = 5;
        expBusy = 1'b1;
`endif

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 4'd0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.imm      = '0;
        bus.use_imm  = 1'b0;
        bus.rd_in    = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("rst_alu_out",   bus.alu_out,            32'd0);
        checkOutput("rst_rd_out",    {27'd0, bus.rd_out},    32'd0);
        checkOutput("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

        // Reset in the middle of SLL by 20.
        issue(4'd2, 32'h0000_0001, 32'd20, 32'd0, 1'b0, 5'd6);
        checkOutput("sll20_busy", {31'd0, bus.busy}, {31'd0, expBusy});
        repeat (4) step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midrst_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("midrst_alu_out",   bus.alu_out,            32'd0);
        checkOutput("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        repeat (25) step();
        checkOutput("midrst_no_late_result", {31'd0, bus.out_valid}, 32'd0);

        // ADD and SUB, latency 1.
        issue(4'd0, 32'd7, 32'd5, 32'd0, 1'b0, 5'd3);
        checkOutput("add_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("add_result", bus.alu_out, 32'd12);
        checkOutput("add_rd", {27'd0, bus.rd_out}, 32'd3);
        issue(4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 5'd4);
        checkOutput("sub_result", bus.alu_out, 32'hFFFF_FFFF);
        checkOutput("sub_rd", {27'd0, bus.rd_out}, 32'd4);
        step();
        checkOutput("sub_retired", {31'd0, bus.out_valid}, 32'd0);

        // SRA 0x80000000 by immediate 4.
        issue(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd7);
        checkOutput("sra_busy", {31'd0, bus.busy}, {31'd0, expBusy});
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("sra_latency", n, expLat);
        checkOutput("sra_result", bus.alu_out, 32'hF800_0000);
        checkOutput("sra_rd", {27'd0, bus.rd_out}, 32'd7);
        checkOutput("sra_busy_done", {31'd0, bus.busy}, 32'd0);
        step();

        // SRL by 4 (zero fill) and shift with shamt 0 (B=32 -> B[4:0]=0).
        issue(4'd6, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd8);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("srl_latency", n, expLat);
        checkOutput("srl_result", bus.alu_out, 32'h0800_0000);
        step();
        issue(4'd7, 32'h8000_00F0, 32'd32, 32'd0, 1'b0, 5'd9);
        checkOutput("sra0_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("sra0_result", bus.alu_out, 32'h8000_00F0);

        // Compares, logic ops, PASSB and an illegal op.
        issue(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1);
        checkOutput("slt_result", bus.alu_out, 32'd1);
        issue(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1);
        checkOutput("sltu_result", bus.alu_out, 32'd0);
        issue(4'd5, 32'hF0F0_1234, 32'h0FF0_00FF, 32'd0, 1'b0, 5'd2);
        checkOutput("xor_result", bus.alu_out, 32'hFF00_12CB);
        issue(4'd8, 32'hF000_0000, 32'h0000_000F, 32'd0, 1'b0, 5'd2);
        checkOutput("or_result", bus.alu_out, 32'hF000_000F);
        issue(4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 5'd2);
        checkOutput("and_result", bus.alu_out, 32'h0F00_0F00);
        issue(4'd10, 32'h1234_5678, 32'd0, 32'hABCD_E000, 1'b1, 5'd5);
        checkOutput("passb_result", bus.alu_out, 32'hABCD_E000);
        issue(4'd13, 32'd9, 32'd9, 32'd0, 1'b0, 5'd0);
        checkOutput("illegal_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("illegal_result", bus.alu_out, 32'd0);
        checkOutput("rd_zero_pass", {27'd0, bus.rd_out}, 32'd0);

        // Backpressure: result held, later inputs ignored.
        issue(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd9);
        bus.out_ready = 1'b0;
        #1;
        checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        applyStimulus(4'd0, 32'd100, 32'd1, 32'd0, 1'b0, 5'd11);
        step();
        step();
        checkOutput("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("bp_result_held", bus.alu_out, 32'd5);
        checkOutput("bp_rd_held", {27'd0, bus.rd_out}, 32'd9);
        applyStimulus(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd10);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("bp_next_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("bp_next_result", bus.alu_out, 32'd30);
        checkOutput("bp_next_rd", {27'd0, bus.rd_out}, 32'd10);

        // Streaming 8 ADDs back to back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'd0, i * 16, i + 1, 32'd0, 1'b0, 5'(i + 2));
            step();
            checkOutput("stream_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("stream_result", bus.alu_out, i * 17 + 1);
            checkOutput("stream_rd", {27'd0, bus.rd_out}, i + 2);
        end
        bus.in_valid = 1'b0;
        step();
        checkOutput("stream_drained", {31'd0, bus.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
